// File: rtl/sipo_pkg.sv
// Shared types and constants for the SIPO frame deserializer.
// Optional parity checking is enabled by defining SIPO_PARITY_CHECK_EN.
package sipo_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam bit DEF_MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sipo_state_t;

    // Bit counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// One-deep valid/ready holding register for assembled words.
// A word offered while the register is full and not being drained is
// dropped and raises a sticky overrun flag.
module sipo_out_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             overrun_q;
    logic             accept_w;

    assign accept_w = valid_q & ready_i;

    // Load, drain or drop; acceptance in the same cycle frees the slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (load_i) begin
                if (!valid_q || accept_w) begin
                    data_q  <= data_i;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (accept_w) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/sipo_frame_deserializer.sv
// Serial-to-parallel frame deserializer with frame-start alignment,
// resync detection and a one-deep valid/ready output register.
// Define SIPO_PARITY_CHECK_EN to require a trailing even-parity bit.
//
//  state  | meaning
//  IDLE   | waiting for bit_valid & frame_start
//  SHIFT  | collecting data bits, count_q bits taken so far
//  PARITY | all data bits held, waiting for the parity bit
module sipo_frame_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    sipo_state_t      state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             frame_err_q;
    logic             parity_err_q;

    logic             start_w;
    logic             data_bit_w;
    logic             complete_w;
    logic [WIDTH-1:0] word_w;
`ifdef SIPO_PARITY_CHECK_EN
    logic             parity_bit_w;
    logic             parity_bad_w;
`endif

    assign start_w    = bit_valid & frame_start;
    assign data_bit_w = bit_valid & ~frame_start & (state_q == SHIFT);

    // Shift register next value: a frame start always restarts the word.
    always_comb begin
        shift_d = shift_q;
        if (start_w) begin
            if (MSB_FIRST) shift_d = {{(WIDTH-1){1'b0}}, serial_in};
            else           shift_d = {serial_in, {(WIDTH-1){1'b0}}};
        end else if (data_bit_w) begin
            if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], serial_in};
            else           shift_d = {serial_in, shift_q[WIDTH-1:1]};
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    // Word is only released once its parity bit has been checked.
    assign parity_bit_w = bit_valid & ~frame_start & (state_q == PARITY);
    assign parity_bad_w = parity_bit_w & ((^shift_q) ^ serial_in);
    assign complete_w   = parity_bit_w & ~((^shift_q) ^ serial_in);
    assign word_w       = shift_q;
`else
    assign complete_w   = data_bit_w & (count_q == LAST_IDX);
    assign word_w       = shift_d;
`endif

    // Frame FSM with bit counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            count_q      <= '0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            shift_q      <= shift_d;
            if (bit_valid) begin
                if (frame_start) begin
                    if (state_q != IDLE) frame_err_q <= 1'b1;
                    state_q <= SHIFT;
                    count_q <= CW'(1);
                    busy_q  <= 1'b1;
                end else begin
                    case (state_q)
                        SHIFT: begin
                            if (count_q == LAST_IDX) begin
`ifdef SIPO_PARITY_CHECK_EN
                                state_q <= PARITY;
                                count_q <= count_q + CW'(1);
`else
                                state_q <= IDLE;
                                count_q <= '0;
                                busy_q  <= 1'b0;
`endif
                            end else begin
                                count_q <= count_q + CW'(1);
                            end
                        end
`ifdef SIPO_PARITY_CHECK_EN
                        PARITY: begin
                            state_q      <= IDLE;
                            count_q      <= '0;
                            busy_q       <= 1'b0;
                            parity_err_q <= parity_bad_w;
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    sipo_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (complete_w),
        .data_i   (word_w),
        .ready_i  (out_ready),
        .data_o   (parallel_out),
        .valid_o  (out_valid),
        .overrun_o(overrun)
    );

    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// Directed bench for sipo_frame_deserializer (WIDTH=4, MSB_FIRST=1).
module tb_sipo_frame_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] parallel_out;
    logic       out_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sipo_frame_deserializer #(
        .WIDTH    (4),
        .MSB_FIRST(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .parallel_out(parallel_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    typedef struct {
        logic       r, bv, fs, s, rdy;
        logic       ev, eb, ef, eo, ep;
        logic [3:0] ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, bv, fs, s, rdy,
                               input logic ev, eb, ef, eo,
                               input logic [3:0] ed);
        vec_t x;
        x.r = r; x.bv = bv; x.fs = fs; x.s = s; x.rdy = rdy;
        x.ev = ev; x.eb = eb; x.ef = ef; x.eo = eo; x.ep = 1'b0; x.ed = ed;
        return x;
    endfunction

    // Drive one cycle of inputs, then compare outputs just after the edge.
    task automatic step(input string name, input vec_t x);
        logic [8:0] got, exp;
        rst = x.r; bit_valid = x.bv; frame_start = x.fs;
        serial_in = x.s; out_ready = x.rdy;
        @(posedge clk);
        #1;
        got = {out_valid, busy, frame_err, overrun, parity_err, parallel_out};
        exp = {x.ev, x.eb, x.ef, x.eo, x.ep, x.ed};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got v/b/fe/ov/pe/data=%b required %b", name, got, exp);
        end
    endtask

    initial begin
        vec_t p;
        // r bv fs s rdy | valid busy ferr ovr | data
        // reset and idle
        tbl.push_back(v(0,0,0,0,1, 0,0,0,0, 4'h0));
        tbl.push_back(v(1,0,0,0,1, 0,0,0,0, 4'h0));
        // frame 1011 back to back, out_ready=1
        tbl.push_back(v(1,1,1,1,1, 0,1,0,0, 4'h0));
        tbl.push_back(v(1,1,0,0,1, 0,1,0,0, 4'h0));
        tbl.push_back(v(1,1,0,1,1, 0,1,0,0, 4'h0));
        tbl.push_back(v(1,1,0,1,1, 1,0,0,0, 4'hB));
        tbl.push_back(v(1,0,0,0,1, 0,0,0,0, 4'hB));
        // same frame with two idle cycles between bits
        tbl.push_back(v(1,1,1,1,1, 0,1,0,0, 4'hB));
        tbl.push_back(v(1,0,0,0,1, 0,1,0,0, 4'hB));
        tbl.push_back(v(1,0,0,0,1, 0,1,0,0, 4'hB));
        tbl.push_back(v(1,1,0,0,1, 0,1,0,0, 4'hB));
        tbl.push_back(v(1,0,0,0,1, 0,1,0,0, 4'hB));
        tbl.push_back(v(1,0,0,0,1, 0,1,0,0, 4'hB));
        tbl.push_back(v(1,1,0,1,1, 0,1,0,0, 4'hB));
        tbl.push_back(v(1,0,0,0,1, 0,1,0,0, 4'hB));
        tbl.push_back(v(1,0,0,0,1, 0,1,0,0, 4'hB));
        tbl.push_back(v(1,1,0,1,1, 1,0,0,0, 4'hB));
        tbl.push_back(v(1,0,0,0,1, 0,0,0,0, 4'hB));
        // overrun: 1011 then 0110 with out_ready=0
        tbl.push_back(v(1,1,1,1,0, 0,1,0,0, 4'hB));
        tbl.push_back(v(1,1,0,0,0, 0,1,0,0, 4'hB));
        tbl.push_back(v(1,1,0,1,0, 0,1,0,0, 4'hB));
        tbl.push_back(v(1,1,0,1,0, 1,0,0,0, 4'hB));
        tbl.push_back(v(1,1,1,0,0, 1,1,0,0, 4'hB));
        tbl.push_back(v(1,1,0,1,0, 1,1,0,0, 4'hB));
        tbl.push_back(v(1,1,0,1,0, 1,1,0,0, 4'hB));
        tbl.push_back(v(1,1,0,0,0, 1,0,0,1, 4'hB));
        tbl.push_back(v(1,0,0,0,1, 0,0,0,1, 4'hB));
        tbl.push_back(v(1,0,0,0,1, 0,0,0,1, 4'hB));
        // resync: 1,0 then frame_start with 0,1,1,0
        tbl.push_back(v(1,1,1,1,1, 0,1,0,1, 4'hB));
        tbl.push_back(v(1,1,0,0,1, 0,1,0,1, 4'hB));
        tbl.push_back(v(1,1,1,0,1, 0,1,1,1, 4'hB));
        tbl.push_back(v(1,1,0,1,1, 0,1,0,1, 4'hB));
        tbl.push_back(v(1,1,0,1,1, 0,1,0,1, 4'hB));
        tbl.push_back(v(1,1,0,0,1, 1,0,0,1, 4'h6));
        tbl.push_back(v(1,0,0,0,1, 0,0,0,1, 4'h6));
        // reset after two bits, then clean 1100
        tbl.push_back(v(1,1,1,1,1, 0,1,0,1, 4'h6));
        tbl.push_back(v(1,1,0,1,1, 0,1,0,1, 4'h6));
        tbl.push_back(v(0,0,0,0,1, 0,0,0,0, 4'h0));
        tbl.push_back(v(0,1,1,1,1, 0,0,0,0, 4'h0));
        tbl.push_back(v(1,0,0,0,1, 0,0,0,0, 4'h0));
        tbl.push_back(v(1,1,1,1,1, 0,1,0,0, 4'h0));
        tbl.push_back(v(1,1,0,1,1, 0,1,0,0, 4'h0));
        tbl.push_back(v(1,1,0,0,1, 0,1,0,0, 4'h0));
        tbl.push_back(v(1,1,0,0,1, 1,0,0,0, 4'hC));
        tbl.push_back(v(1,0,0,0,1, 0,0,0,0, 4'hC));
        // frame_start without bit_valid, and data bits in IDLE, are ignored
        tbl.push_back(v(1,0,1,1,1, 0,0,0,0, 4'hC));
        tbl.push_back(v(1,1,0,1,1, 0,0,0,0, 4'hC));
        // completion coinciding with acceptance keeps out_valid high
        tbl.push_back(v(1,1,1,0,0, 0,1,0,0, 4'hC));
        tbl.push_back(v(1,1,0,1,0, 0,1,0,0, 4'hC));
        tbl.push_back(v(1,1,0,0,0, 0,1,0,0, 4'hC));
        tbl.push_back(v(1,1,0,1,0, 1,0,0,0, 4'h5));
        tbl.push_back(v(1,1,1,1,0, 1,1,0,0, 4'h5));
        tbl.push_back(v(1,1,0,1,0, 1,1,0,0, 4'h5));
        tbl.push_back(v(1,1,0,1,0, 1,1,0,0, 4'h5));
        tbl.push_back(v(1,1,0,0,1, 1,0,0,0, 4'hE));
        tbl.push_back(v(1,0,0,0,1, 0,0,0,0, 4'hE));

`ifndef SIPO_PARITY_CHECK_EN
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // long stall mid-frame: state and count hold with no timeout
        step("stall_start", v(1,1,1,0,1, 0,1,0,0, 4'hE));
        for (int i = 0; i < 20; i++)
            step($sformatf("stall%0d", i), v(1,0,0,0,1, 0,1,0,0, 4'hE));
        step("stall_b1", v(1,1,0,0,1, 0,1,0,0, 4'hE));
        step("stall_b2", v(1,1,0,1,1, 0,1,0,0, 4'hE));
        step("stall_b3", v(1,1,0,1,1, 1,0,0,0, 4'h3));
        step("stall_done", v(1,0,0,0,1, 0,0,0,0, 4'h3));
`else
        step("p_rst", v(0,0,0,0,1, 0,0,0,0, 4'h0));
        step("p_idle", v(1,0,0,0,1, 0,0,0,0, 4'h0));
        // 1011 + parity 1: delivered on the parity edge
        step("p_d0", v(1,1,1,1,1, 0,1,0,0, 4'h0));
        step("p_d1", v(1,1,0,0,1, 0,1,0,0, 4'h0));
        step("p_d2", v(1,1,0,1,1, 0,1,0,0, 4'h0));
        step("p_d3", v(1,1,0,1,1, 0,1,0,0, 4'h0));
        step("p_par_ok", v(1,1,0,1,1, 1,0,0,0, 4'hB));
        step("p_acc", v(1,0,0,0,1, 0,0,0,0, 4'hB));
        // 1011 + parity 0: dropped with a parity_err pulse
        step("p_e0", v(1,1,1,1,1, 0,1,0,0, 4'hB));
        step("p_e1", v(1,1,0,0,1, 0,1,0,0, 4'hB));
        step("p_e2", v(1,1,0,1,1, 0,1,0,0, 4'hB));
        step("p_e3", v(1,1,0,1,1, 0,1,0,0, 4'hB));
        p = v(1,1,0,0,1, 0,0,0,0, 4'hB);
        p.ep = 1'b1;
        step("p_par_bad", p);
        step("p_after", v(1,0,0,0,1, 0,0,0,0, 4'hB));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
